// File: rtl/imem_pkg.sv
// imem_pkg: fault codes, NOP encoding and shared constants for the instruction fetch port
package imem_pkg;
  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_MISALIGN = 2'd1,
    FAULT_RANGE    = 2'd2
  } fault_e;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
endpackage

// File: rtl/imem_fetch_port_if.sv
// imem_fetch_port_if: fetch request / decode response bundle, plus the redirect flush
interface imem_fetch_port_if import imem_pkg::*; #(parameter int XLEN = 32);
  logic            flush;
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_pc;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] rsp_instr;
  fault_e          rsp_fault;
  modport master (
    output flush, req_valid, req_pc, rsp_ready,
    input  req_ready, rsp_valid, rsp_pc, rsp_instr, rsp_fault
  );
  modport slave (
    input  flush, req_valid, req_pc, rsp_ready,
    output req_ready, rsp_valid, rsp_pc, rsp_instr, rsp_fault
  );
endinterface

// File: rtl/imem_rsp_fifo.sv
// imem_rsp_fifo: small in-order response buffer with flush; pointers wrap modulo DEPTH
module imem_rsp_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  data_o,
  output logic [CW-1:0] count_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // next pointers and occupancy; flush empties the buffer and overrides push/pop
  always_comb begin
    wr_d  = flush_i ? '0 : push_i ? (wr_q == PW'(DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d  = flush_i ? '0 : pop_i ? (rd_q == PW'(DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d = flush_i ? '0 : cnt_q + CW'(push_i) - CW'(pop_i);
  end
  // pointer and count state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  // entry storage needs no reset; count gates every read
  always_ff @(posedge clk)
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/imem_fetch_port.sv
// imem_fetch_port: synchronous-read instruction memory with in-order valid/ready fetch responses
// Optional IMEM_LOAD_PORT_EN adds a write port (load_en_i/load_addr_i/load_data_i).
module imem_fetch_port import imem_pkg::*; #(
  parameter  int              XLEN      = 32,
  parameter  int              DEPTH     = 1024,
  parameter  logic [XLEN-1:0] BASE_ADDR = '0,
  parameter  int              RSP_DEPTH = 2,
  parameter  string           INIT_FILE = "",
  localparam int              AW        = $clog2(DEPTH),
  localparam int              CW        = $clog2(RSP_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef IMEM_LOAD_PORT_EN
  input  logic            load_en_i,
  input  logic [AW-1:0]   load_addr_i,
  input  logic [XLEN-1:0] load_data_i,
`endif
  imem_fetch_port_if.slave bus
);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    fault_e          fault;
  } imem_rsp_t;
  logic [XLEN-1:0] mem [DEPTH];
  logic [XLEN-2:0] widx;
  fault_e          fault;
  logic            req_fire, pop, fifo_pop, push, infl_q, infl_d;
  imem_rsp_t       data_q, data_d, fifo_head, head, rsp;
  logic [CW-1:0]   count;
  // memory starts at zero
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end
`ifdef IMEM_LOAD_PORT_EN
  // write port ignores reset; a same-edge read still sees the old word
  always_ff @(posedge clk)
    if (load_en_i) mem[load_addr_i] <= load_data_i;
`endif
  // word index with a borrow bit, so PCs below the base land out of range instead of wrapping
  assign widx     = {1'b0, bus.req_pc[XLEN-1:2]} - {1'b0, BASE_ADDR[XLEN-1:2]};
  assign fault    = |bus.req_pc[1:0] ? FAULT_MISALIGN :
                    widx >= (XLEN-1)'(DEPTH) ? FAULT_RANGE : FAULT_NONE;
  assign req_fire = bus.req_valid && bus.req_ready;
  assign infl_d   = req_fire;
  // next in-flight response; faulting fetches carry a NOP
  always_comb begin
    data_d.pc    = bus.req_pc;
    data_d.instr = fault == FAULT_NONE ? mem[widx[AW-1:0]] : XLEN'(NOP_INSTR);
    data_d.fault = fault;
  end
  // in-flight read register; flush does not cancel a request accepted in the same cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      infl_q <= 1'b0;
      data_q <= '0;
    end else begin
      infl_q <= infl_d;
      if (req_fire) data_q <= data_d;
    end
  // the in-flight word bypasses the buffer when it is empty and popped at once
  assign pop      = bus.rsp_valid && bus.rsp_ready && !bus.flush;
  assign fifo_pop = pop && count != '0;
  assign push     = infl_q && !bus.flush && !(pop && count == '0);
  imem_rsp_fifo #(.W($bits(imem_rsp_t)), .DEPTH(RSP_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (fifo_pop),
    .flush_i (bus.flush),
    .data_i  (data_q),
    .data_o  (fifo_head),
    .count_o (count)
  );
  assign bus.req_ready = int'(count) + int'(infl_q) < RSP_DEPTH;
  assign bus.rsp_valid = count != '0 || infl_q;
  assign head          = count != '0 ? fifo_head : data_q;
  assign rsp           = bus.rsp_valid ? head : '0;
  assign bus.rsp_pc    = rsp.pc;
  assign bus.rsp_instr = rsp.instr;
  assign bus.rsp_fault = rsp.fault;
endmodule

// File: tb/tb_imem_fetch_port.sv
// tb_imem_fetch_port: directed table and sequence checks for imem_fetch_port
module tb_imem_fetch_port;
  import imem_pkg::*;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  fault;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  imem_fetch_port_if b0 ();
  imem_fetch_port_if b1 ();
  int pass_n = 0;
  int total_n = 0;
  logic [31:0] words [4] = '{32'h00500113, 32'h00300193, 32'h003100b3, 32'h40310133};
  vec_t v0 [8];
  vec_t v1 [5];
`ifdef IMEM_LOAD_PORT_EN
  logic        ld_en0 = 1'b0, ld_en1 = 1'b0;
  logic [9:0]  ld_addr0 = '0;
  logic [1:0]  ld_addr1 = '0;
  logic [31:0] ld_data = '0;
`endif
  imem_fetch_port u0 (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef IMEM_LOAD_PORT_EN
    .load_en_i   (ld_en0),
    .load_addr_i (ld_addr0),
    .load_data_i (ld_data),
`endif
    .bus         (b0)
  );
  imem_fetch_port #(.DEPTH(4), .BASE_ADDR(32'h100), .RSP_DEPTH(4)) u1 (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef IMEM_LOAD_PORT_EN
    .load_en_i   (ld_en1),
    .load_addr_i (ld_addr1),
    .load_data_i (ld_data),
`endif
    .bus         (b1)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int idx, got;
    logic fire;
    b0.flush = 0; b0.req_valid = 0; b0.req_pc = '0; b0.rsp_ready = 1;
    b1.flush = 0; b1.req_valid = 0; b1.req_pc = '0; b1.rsp_ready = 1;
    for (int i = 0; i < 4; i++) v0[i] = '{32'(i) * 4, words[i], 2'd0};
    v0[4] = '{32'h6,    NOP_INSTR, 2'd1};
    v0[5] = '{32'h1000, NOP_INSTR, 2'd2};
    v0[6] = '{32'hFFC,  32'h0,     2'd0};
    v0[7] = '{32'h1001, NOP_INSTR, 2'd1};
    v1[0] = '{32'h2,    NOP_INSTR, 2'd1};
    v1[1] = '{32'h0,    NOP_INSTR, 2'd2};
    v1[2] = '{32'h110,  NOP_INSTR, 2'd2};
    v1[3] = '{32'h104,  words[1],  2'd0};
    v1[4] = '{32'h10C,  words[3],  2'd0};
    #1;
`ifdef IMEM_LOAD_PORT_EN
    for (int i = 0; i < 4; i++) begin
      ld_en0 = 1; ld_en1 = 1; ld_addr0 = 10'(i); ld_addr1 = 2'(i); ld_data = words[i];
      tick();
    end
    ld_en0 = 0; ld_en1 = 0;
`else
    for (int i = 0; i < 4; i++) begin
      u0.mem[i] = words[i];
      u1.mem[i] = words[i];
    end
    repeat (2) tick();
`endif
    chk("reset rsp_valid", b0.rsp_valid, 0);
    chk("reset rsp_pc", b0.rsp_pc, 0);
    chk("reset rsp_instr", b0.rsp_instr, 0);
    chk("reset rsp_fault", b0.rsp_fault, 0);
    rst_n = 1;
    tick();
    chk("ready after release", b0.req_ready, 1);
    chk("idle after release", b0.rsp_valid, 0);
    // streaming table: one request per cycle, response one cycle later
    for (int i = 0; i < 8; i++) begin
      b0.req_valid = 1; b0.req_pc = v0[i].pc;
      chk("stream req_ready", b0.req_ready, 1);
      tick();
      chk("stream rsp_valid", b0.rsp_valid, 1);
      chk("stream rsp_pc", b0.rsp_pc, v0[i].pc);
      chk("stream rsp_instr", b0.rsp_instr, v0[i].instr);
      chk("stream rsp_fault", b0.rsp_fault, v0[i].fault);
    end
    b0.req_valid = 0;
    tick();
    chk("stream drained", b0.rsp_valid, 0);
    // nonzero base table on the second instance
    for (int i = 0; i < 5; i++) begin
      b1.req_valid = 1; b1.req_pc = v1[i].pc;
      tick();
      chk("base rsp_pc", b1.rsp_pc, v1[i].pc);
      chk("base rsp_instr", b1.rsp_instr, v1[i].instr);
      chk("base rsp_fault", b1.rsp_fault, v1[i].fault);
    end
    b1.req_valid = 0;
    tick();
    // back-pressure: issue stops after two accepts, head holds stable
    b0.rsp_ready = 0; idx = 0;
    for (int c = 0; c < 5; c++) begin
      b0.req_valid = 1; b0.req_pc = 32'(idx) * 4;
      fire = b0.req_ready;
      tick();
      if (fire) idx++;
      chk("stall valid", b0.rsp_valid, 1);
      chk("stall hold pc", b0.rsp_pc, 0);
      chk("stall hold instr", b0.rsp_instr, words[0]);
    end
    chk("accepts before stall", idx, 2);
    chk("req_ready stalled", b0.req_ready, 0);
    b0.rsp_ready = 1; got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      b0.req_valid = idx < 4; b0.req_pc = 32'(idx) * 4;
      fire = b0.req_valid && b0.req_ready;
      if (b0.rsp_valid) begin
        chk("drain pc", b0.rsp_pc, 32'(got) * 4);
        chk("drain instr", b0.rsp_instr, words[got]);
        got++;
      end
      tick();
      if (fire) idx++;
    end
    b0.req_valid = 0;
    chk("drain count", got, 4);
    chk("no duplicate", b0.rsp_valid, 0);
    // flush with two buffered, one in flight and a same-cycle request
    b1.rsp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      b1.req_valid = 1; b1.req_pc = 32'h100 + 32'(i) * 4;
      chk("fill ready", b1.req_ready, 1);
      tick();
    end
    chk("fill head pc", b1.rsp_pc, 32'h100);
    b1.flush = 1; b1.rsp_ready = 1; b1.req_pc = 32'h10C;
    chk("flush cycle ready", b1.req_ready, 1);
    tick();
    b1.flush = 0; b1.req_valid = 0;
    chk("post flush valid", b1.rsp_valid, 1);
    chk("post flush pc", b1.rsp_pc, 32'h10C);
    chk("post flush instr", b1.rsp_instr, 32'h40310133);
    chk("post flush fault", b1.rsp_fault, 0);
    tick();
    chk("post flush only one", b1.rsp_valid, 0);
`ifdef IMEM_LOAD_PORT_EN
    // write and read of the same word on one edge returns the old word
    ld_en0 = 1; ld_addr0 = 10'd2; ld_data = 32'hdeadbeef;
    b0.req_valid = 1; b0.req_pc = 32'h8;
    tick();
    ld_en0 = 0;
    chk("load old word", b0.rsp_instr, 32'h003100b3);
    tick();
    chk("load new word", b0.rsp_instr, 32'hdeadbeef);
    b0.req_valid = 0;
    tick();
`endif
    // asynchronous reset mid-stream drops everything
    b0.rsp_ready = 0;
    for (int i = 0; i < 2; i++) begin
      b0.req_valid = 1; b0.req_pc = 32'(i) * 4;
      tick();
    end
    chk("pre reset valid", b0.rsp_valid, 1);
    #3 rst_n = 0;
    #1;
    chk("async reset valid", b0.rsp_valid, 0);
    b0.req_valid = 0;
    repeat (2) tick();
    rst_n = 1;
    tick();
    chk("post reset ready", b0.req_ready, 1);
    b0.rsp_ready = 1;
    for (int i = 0; i < 3; i++) begin
      chk("no stale rsp", b0.rsp_valid, 0);
      tick();
    end
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
